// File: rtl/opb_status_snapshot_ctrl_pkg.sv
// Shared constants for the OPB status snapshot controller: register word
// offsets, CTRL bit positions and the bus/capture FSM encodings.
package opb_status_snapshot_ctrl_pkg;

  localparam int OFF_W = 30;

  localparam logic [OFF_W-1:0] REG_CTRL   = 30'd0;
  localparam logic [OFF_W-1:0] REG_SEQ    = 30'd1;
  localparam logic [OFF_W-1:0] REG_PERIOD = 30'd2;
  localparam logic [OFF_W-1:0] REG_RSVD   = 30'd3;
  localparam logic [OFF_W-1:0] REG_WORD0  = 30'd4;

  // Bit 0 is "trigger" on write and "busy" on read.
  localparam int CTRL_TRIG_BIT  = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_VALID_BIT = 2;
  localparam int CTRL_OVR_BIT   = 3;

  typedef enum logic {
    BIDLE = 1'b0,
    BACK  = 1'b1
  } bus_state_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } cap_state_e;

endpackage

// File: rtl/opb_status_snapshot_period_tmr.sv
// Free-running auto-snapshot period counter; only instantiated when
// SNAPSHOT_AUTO_EN is defined.
module opb_status_snapshot_period_tmr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        restart_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] count_q, count_d;
  logic        running;

  assign running = en_i && (period_i != 32'd0);
  assign tick_o  = running && !restart_i && (count_q == period_i - 32'd1);

  always_comb begin
    count_d = count_q + 32'd1;
    if (!running || restart_i || tick_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/opb_status_snapshot_ctrl.sv
// OPB slave that arms, coherently captures and serves a bank of status words.
// Define SNAPSHOT_AUTO_EN to build the auto-trigger period timer and PERIOD reg.
module opb_status_snapshot_ctrl
  import opb_status_snapshot_ctrl_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFF_FFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_0000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_WORDS  = 4,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [C_NUM_WORDS*32-1:0] user_data_in,
  input  logic                      user_valid,
  output logic                      snap_busy
);

  localparam logic [OFF_W-1:0] NUM_WORDS_W = OFF_W'(C_NUM_WORDS);

  // OPB numbers bits MSB-first; positional assignment maps OPB bit n to bit 31-n.
  logic [31:0] abus_le, dbus_le, off_full, rdata_le;
  logic [3:0]  be_le;
  logic        in_win;

  assign abus_le  = OPB_ABus;
  assign dbus_le  = OPB_DBus;
  assign be_le    = OPB_BE;
  assign off_full = abus_le - C_BASEADDR;
  assign in_win   = (abus_le >= C_BASEADDR) && (abus_le <= C_HIGHADDR);

  bus_state_e       bus_q, bus_d;
  logic [OFF_W-1:0] woff_q, woff_d;
  logic             rnw_q, rnw_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;

  always_comb begin
    bus_d   = bus_q;
    woff_d  = woff_q;
    rnw_d   = rnw_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (bus_q)
      BIDLE: begin
        if (OPB_select && in_win) begin
          bus_d   = BACK;
          woff_d  = off_full[31:2];
          rnw_d   = OPB_RNW;
          wdata_d = dbus_le;
          be_d    = be_le;
        end
      end
      BACK:    bus_d = BIDLE;
      default: bus_d = BIDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      bus_q   <= BIDLE;
      woff_q  <= '0;
      rnw_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      bus_q   <= bus_d;
      woff_q  <= woff_d;
      rnw_q   <= rnw_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  logic ack, wr_en, rd_en, ctrl_wr, trig, ovr_clr, period_wr;

  assign ack       = (bus_q == BACK);
  assign wr_en     = ack && !rnw_q;
  assign rd_en     = ack && rnw_q;
  assign ctrl_wr   = wr_en && (woff_q == REG_CTRL) && be_q[0];
  assign trig      = ctrl_wr && wdata_q[CTRL_TRIG_BIT];
  assign ovr_clr   = ctrl_wr && wdata_q[CTRL_OVR_BIT];
  assign period_wr = wr_en && (woff_q == REG_PERIOD);

  logic        auto_val, tick;
  logic [31:0] period_val;

`ifdef SNAPSHOT_AUTO_EN
  logic        auto_q, auto_d;
  logic [31:0] period_q, period_d;

  always_comb begin
    auto_d   = auto_q;
    period_d = period_q;
    if (ctrl_wr) begin
      auto_d = wdata_q[CTRL_AUTO_BIT];
    end
    if (period_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          period_d[8*b +: 8] = wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      auto_q   <= 1'b0;
      period_q <= '0;
    end else begin
      auto_q   <= auto_d;
      period_q <= period_d;
    end
  end

  opb_status_snapshot_period_tmr u_period_tmr (
    .clk_i     (OPB_Clk),
    .rst_i     (OPB_Rst),
    .en_i      (auto_q),
    .restart_i (period_wr),
    .period_i  (period_q),
    .tick_o    (tick)
  );

  assign auto_val   = auto_q;
  assign period_val = period_q;
`else
  assign auto_val   = 1'b0;
  assign period_val = '0;
  assign tick       = 1'b0;
`endif

  cap_state_e  cap_q, cap_d;
  logic        capture, ovr_set, arm_req;
  logic        ovr_q, ovr_d, valid_q, valid_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] snap_q [C_NUM_WORDS];

  // A trigger and a tick landing together are a single arm request.
  assign arm_req = trig || tick;

  always_comb begin
    cap_d   = cap_q;
    capture = 1'b0;
    ovr_set = 1'b0;
    case (cap_q)
      IDLE: begin
        if (arm_req) cap_d = ARMED;
      end
      ARMED: begin
        ovr_set = arm_req;
        if (user_valid) begin
          capture = 1'b1;
          cap_d   = IDLE;
        end
      end
      default: cap_d = IDLE;
    endcase
  end

  assign seq_d   = capture ? seq_q + 32'd1 : seq_q;
  assign valid_d = valid_q || capture;
  assign ovr_d   = (ovr_q && !ovr_clr) || ovr_set;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      cap_q   <= IDLE;
      seq_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < C_NUM_WORDS; k++) snap_q[k] <= '0;
    end else begin
      cap_q   <= cap_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      if (capture) begin
        for (int k = 0; k < C_NUM_WORDS; k++) snap_q[k] <= user_data_in[32*k +: 32];
      end
    end
  end

  logic [OFF_W-1:0] word_sel;
  logic [31:0]      ctrl_rd;

  assign word_sel = woff_q - REG_WORD0;
  assign ctrl_rd  = {16'h0, 8'(C_NUM_WORDS), 4'h0, ovr_q, valid_q, auto_val, (cap_q == ARMED)};

  // Reads see registered state, so a read coinciding with capture is pre-capture.
  always_comb begin
    rdata_le = '0;
    if (rd_en) begin
      if (woff_q == REG_CTRL) begin
        rdata_le = ctrl_rd;
      end else if (woff_q == REG_SEQ) begin
        rdata_le = seq_q;
      end else if (woff_q == REG_PERIOD) begin
        rdata_le = period_val;
      end else if (woff_q >= REG_WORD0 && word_sel < NUM_WORDS_W) begin
        for (int k = 0; k < C_NUM_WORDS; k++) begin
          if (word_sel == OFF_W'(k)) rdata_le = snap_q[k];
        end
      end
    end
  end

  assign Sl_DBus    = rdata_le;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign snap_busy  = (cap_q == ARMED);

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, off_full[1:0], period_wr, auto_val, REG_RSVD,
                       32'(C_OPB_AWIDTH), 32'(C_OPB_DWIDTH)};

endmodule
